// File: rtl/decode_pkg.sv
// ============================================================================
// decode_pkg : shared constants and FSM state type for the decode scoreboard
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int NREG  = 16;
    localparam int AW    = 4;
    localparam int CNT_W = 16;

    localparam logic [3:0] REG_LINK = 4'd14;
    localparam logic [3:0] REG_V    = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sb_pending.sv
// ============================================================================
// sb_pending : per-register pending-write bit vector with set/clear
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module sb_pending #(
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREG-1:0] set_i,
    input  logic [NREG-1:0] clr_i,
    output logic [NREG-1:0] busy_map_o,
    output logic [NREG-1:0] busy_next_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // A new issue to a register being retired this cycle keeps it pending.
    assign busy_d      = (busy_q & ~clr_i) | set_i;
    assign busy_map_o  = busy_q;
    assign busy_next_o = busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_scoreboard.sv
// ============================================================================
// decode_scoreboard : Decode-stage issue controller with RAW/WAW scoreboard,
//                     drain handshake and stall statistics
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module decode_scoreboard import decode_pkg::*; #(
    parameter int NREG  = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [AW-1:0]    id_rp_i,
    input  logic [AW-1:0]    id_rs_i,
    input  logic [AW-1:0]    id_rg_i,
    input  logic             id_sel_a_i,
    input  logic             id_sel_b_i,
    input  logic             id_sel_c_i,
    input  logic             id_use_a_i,
    input  logic             id_use_b_i,
    input  logic             id_wr_c_i,
    input  logic             id_wr_v_i,
    input  logic             ex_ready_i,
    input  logic             wb_we_c_i,
    input  logic [AW-1:0]    wb_rg_i,
    input  logic             wb_sel_c_i,
    input  logic             wb_we_v_i,
    input  logic             drain_req_i,
    output logic             issue_o,
    output logic             id_stall_o,
    output logic             drained_o,
    output logic [NREG-1:0]  busy_map_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             sb_err_o
);

    localparam logic [AW-1:0] C_LINK = AW'(REG_LINK);
    localparam logic [AW-1:0] C_V    = AW'(REG_V);

    state_t state_q, state_d;

    logic [AW-1:0]    ea, eb, ec, wc;
    logic [NREG-1:0]  clr, set, busy_eff, busy_map, busy_next;
    logic             hazard, issue, retire_err;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             sb_err_q, sb_err_d;

    assign ea = id_sel_a_i ? C_LINK : id_rp_i;
    assign eb = id_sel_b_i ? C_V    : id_rs_i;
    assign ec = id_sel_c_i ? C_LINK : id_rg_i;
    assign wc = wb_sel_c_i ? C_LINK : wb_rg_i;

    assign clr = ({NREG{wb_we_c_i}} & (NREG'(1) << wc))
               | ({NREG{wb_we_v_i}} & (NREG'(1) << C_V));

    // Bank writes before read: a register retiring this cycle is already free.
    assign busy_eff = busy_map & ~clr;

    assign hazard = (id_use_a_i & busy_eff[ea])
                  | (id_use_b_i & busy_eff[eb])
                  | (id_wr_c_i  & busy_eff[ec])
                  | (id_wr_v_i  & busy_eff[C_V]);

    assign issue = id_valid_i & ~hazard & ex_ready_i
                 & (state_q == ST_RUN) & ~drain_req_i;

    assign set = ({NREG{issue & id_wr_c_i}} & (NREG'(1) << ec))
               | ({NREG{issue & id_wr_v_i}} & (NREG'(1) << C_V));

    assign retire_err = (wb_we_c_i & ~busy_map[wc])
                      | (wb_we_v_i & ~busy_map[C_V]);

    sb_pending #(
        .NREG (NREG)
    ) u_pending (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_i       (set),
        .clr_i       (clr),
        .busy_map_o  (busy_map),
        .busy_next_o (busy_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (drain_req_i)        state_d = ST_DRAIN;
            ST_DRAIN:  if (busy_next == '0)    state_d = ST_HALTED;
            ST_HALTED: if (!drain_req_i)       state_d = ST_RUN;
            default:                           state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        sb_err_d = sb_err_q | retire_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign issue_o     = issue;
    assign id_stall_o  = id_valid_i & ~issue;
    assign drained_o   = (state_q == ST_HALTED);
    assign busy_map_o  = busy_map;
    assign stall_cnt_o = stall_cnt_q;
    assign sb_err_o    = sb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
// ============================================================================
// tb_decode_scoreboard : directed + randomized bench with a register-array
//                        reference model of the decode scoreboard
// Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_sel_a, id_sel_b, id_sel_c, id_use_a, id_use_b;
    logic        id_wr_c, id_wr_v, ex_ready, wb_we_c, wb_sel_c, wb_we_v, drain_req;
    logic [3:0]  id_rp, id_rs, id_rg, wb_rg;
    logic        issue, id_stall, drained, sb_err;
    logic [15:0] busy_map, stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending flags, mode (0 run, 1 draining, 2 halted)
    bit pend [16];
    bit m_ret [16];
    int m_mode;
    int m_cnt;
    bit m_err;
    bit e_issue;

    always #5 clk = ~clk;

    decode_scoreboard #(.NREG(16), .AW(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid_i  (id_valid),
        .id_rp_i     (id_rp),
        .id_rs_i     (id_rs),
        .id_rg_i     (id_rg),
        .id_sel_a_i  (id_sel_a),
        .id_sel_b_i  (id_sel_b),
        .id_sel_c_i  (id_sel_c),
        .id_use_a_i  (id_use_a),
        .id_use_b_i  (id_use_b),
        .id_wr_c_i   (id_wr_c),
        .id_wr_v_i   (id_wr_v),
        .ex_ready_i  (ex_ready),
        .wb_we_c_i   (wb_we_c),
        .wb_rg_i     (wb_rg),
        .wb_sel_c_i  (wb_sel_c),
        .wb_we_v_i   (wb_we_v),
        .drain_req_i (drain_req),
        .issue_o     (issue),
        .id_stall_o  (id_stall),
        .drained_o   (drained),
        .busy_map_o  (busy_map),
        .stall_cnt_o (stall_cnt),
        .sb_err_o    (sb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_sel_a = 0; id_sel_b = 0; id_sel_c = 0;
        id_use_a = 0; id_use_b = 0; id_wr_c = 0; id_wr_v = 0;
        id_rp = 0; id_rs = 0; id_rg = 0; ex_ready = 1;
        wb_we_c = 0; wb_rg = 0; wb_sel_c = 0; wb_we_v = 0;
    endtask

    function automatic logic [15:0] model_map();
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = pend[r];
        return v;
    endfunction

    task automatic predict();
        int ea, eb, ec, wc;
        bit haz;
        ea = id_sel_a ? 14 : int'(id_rp);
        eb = id_sel_b ? 15 : int'(id_rs);
        ec = id_sel_c ? 14 : int'(id_rg);
        wc = wb_sel_c ? 14 : int'(wb_rg);
        for (int r = 0; r < 16; r++)
            m_ret[r] = (wb_we_c && wc == r) || (wb_we_v && r == 15);
        haz = (id_use_a && pend[ea] && !m_ret[ea]) ||
              (id_use_b && pend[eb] && !m_ret[eb]) ||
              (id_wr_c  && pend[ec] && !m_ret[ec]) ||
              (id_wr_v  && pend[15] && !m_ret[15]);
        e_issue = id_valid && !haz && ex_ready && m_mode == 0 && !drain_req;
    endtask

    task automatic advance();
        int ec, wc;
        bit empty;
        ec = id_sel_c ? 14 : int'(id_rg);
        wc = wb_sel_c ? 14 : int'(wb_rg);
        if (wb_we_c && !pend[wc]) m_err = 1;
        if (wb_we_v && !pend[15]) m_err = 1;
        empty = 1;
        for (int r = 0; r < 16; r++) begin
            pend[r] = (pend[r] && !m_ret[r]) ||
                      (e_issue && ((id_wr_c && ec == r) || (id_wr_v && r == 15)));
            if (pend[r]) empty = 0;
        end
        if (id_valid && !e_issue && m_cnt < 65535) m_cnt++;
        case (m_mode)
            0: if (drain_req) m_mode = 1;
            1: if (empty)     m_mode = 2;
            default: if (!drain_req) m_mode = 0;
        endcase
    endtask

    task automatic cycle();
        #1;
        predict();
        check("issue",     {31'd0, issue},    {31'd0, e_issue});
        check("id_stall",  {31'd0, id_stall}, {31'd0, id_valid && !e_issue});
        check("drained",   {31'd0, drained},  {31'd0, m_mode == 2});
        check("busy_map",  {16'd0, busy_map}, {16'd0, model_map()});
        check("stall_cnt", {16'd0, stall_cnt}, m_cnt);
        check("sb_err",    {31'd0, sb_err},   {31'd0, m_err});
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        drain_req = 0;
        #1 rst_n = 0;
        #2;
        check("rst_issue",   {31'd0, issue},    0);
        check("rst_stall",   {31'd0, id_stall}, 0);
        check("rst_drained", {31'd0, drained},  0);
        check("rst_map",     {16'd0, busy_map}, 0);
        check("rst_cnt",     {16'd0, stall_cnt}, 0);
        check("rst_err",     {31'd0, sb_err},   0);
        for (int r = 0; r < 16; r++) pend[r] = 0;
        m_mode = 0; m_cnt = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1;
        drain_req = 0;
        idle();
        @(negedge clk);
        do_reset();

        // RAW on R3 released by same-cycle writeback
        id_valid = 1; id_wr_c = 1; id_rg = 3; cycle();
        id_wr_c = 0; id_use_a = 1; id_rp = 3;
        #1 check("raw_stall", {31'd0, id_stall}, 1);
        cycle(); cycle();
        wb_we_c = 1; wb_rg = 3;
        #1 check("raw_release", {31'd0, issue}, 1);
        cycle(); idle(); cycle();

        // Link register via selects and via explicit address
        id_valid = 1; id_wr_c = 1; id_sel_c = 1; cycle();
        id_wr_c = 0; id_sel_c = 0; id_use_a = 1; id_sel_a = 1;
        #1 check("link_sel_stall", {31'd0, id_stall}, 1);
        cycle();
        id_sel_a = 0; id_rp = 14;
        #1 check("link_addr_stall", {31'd0, id_stall}, 1);
        cycle();
        wb_we_c = 1; wb_sel_c = 1; cycle(); idle(); cycle();

        // V write retired while a new V write issues
        id_valid = 1; id_wr_v = 1; cycle();
        wb_we_v = 1;
        #1 check("v_reissue", {31'd0, issue}, 1);
        cycle(); idle();
        #1 check("v_hold", {31'd0, busy_map[15]}, 1);
        cycle();
        wb_we_v = 1; cycle(); idle(); cycle();

        // Drain with R2 and R5 pending
        id_valid = 1; id_wr_c = 1; id_rg = 2; cycle();
        id_rg = 5; cycle();
        id_wr_c = 0; id_use_a = 1; id_rp = 0; drain_req = 1;
        #1 check("drain_block", {31'd0, issue}, 0);
        cycle();
        id_valid = 0; wb_we_c = 1; wb_rg = 2; cycle();
        wb_rg = 5; cycle();
        wb_we_c = 0;
        #1 check("drained_set", {31'd0, drained}, 1);
        cycle();
        drain_req = 0; cycle();
        id_valid = 1;
        #1 check("run_again", {31'd0, issue}, 1);
        cycle(); idle(); cycle();

        // Retire of a non-pending register
        wb_we_c = 1; wb_rg = 7; cycle(); idle();
        #1 check("err_sticky", {31'd0, sb_err}, 1);
        check("err_map", {16'd0, busy_map}, 0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            id_valid = ($urandom % 4) != 0;
            id_rp = 4'($urandom); id_rs = 4'($urandom); id_rg = 4'($urandom);
            id_sel_a = ($urandom % 4) == 0; id_sel_b = ($urandom % 4) == 0;
            id_sel_c = ($urandom % 5) == 0;
            id_use_a = 1'($urandom); id_use_b = 1'($urandom);
            id_wr_c = 1'($urandom); id_wr_v = ($urandom % 6) == 0;
            ex_ready = ($urandom % 5) != 0;
            r = $urandom_range(0, 15);
            wb_sel_c = 0; wb_rg = 4'(r);
            wb_we_c = pend[r] && ($urandom % 2 == 0);
            wb_we_v = pend[15] && ($urandom % 3 == 0);
            if ($urandom % 200 == 0) begin
                wb_we_c = 1;
                wb_rg = 4'($urandom);
            end
            if ($urandom % 40 == 0) drain_req = !drain_req;
            cycle();
        end
        drain_req = 0;
        idle();
        for (int r = 0; r < 16; r++) begin
            wb_we_c = pend[r]; wb_rg = 4'(r); cycle();
        end
        idle(); cycle(); cycle();

        // Reset while draining
        id_valid = 1; id_wr_c = 1; id_rg = 9; cycle();
        idle(); drain_req = 1; cycle(); cycle();
        do_reset();
        id_valid = 1; id_use_a = 1; id_rp = 9;
        #1 check("post_rst_issue", {31'd0, issue}, 1);
        cycle(); idle(); cycle();

        // Stall counter saturation
        id_valid = 1; ex_ready = 0;
        for (int n = 0; n < 65540; n++) @(posedge clk);
        m_cnt = (m_cnt + 65540 > 65535) ? 65535 : m_cnt + 65540;
        @(negedge clk);
        check("cnt_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        cycle();
        idle(); cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
